pid_plant_model: RTL and testbench

- Discrete-time second-order plant model: ydd = (u - B*yd - C*y) / 2^GAIN_SHIFT, integrated by forward Euler with step 2^-DT_SHIFT.
- Forms the responder end of the PID control loop. The controller issues a control effort u; this block returns the next plant output y after one integration step.
- Lets the controller FSM and the plant be simulated and verified as separate blocks.
- Uses one time-shared multiplier, sequenced by a small FSM.

---
 rtl/pid_pkg.sv | 34 +++
 rtl/sat_add32.sv | 23 ++
 rtl/pid_plant_model.sv | 119 +++++++++++
 tb/tb_pid_plant_model.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared definitions for the PID loop blocks.
// - state_t      : plant sequencer states
// - DEF_*        : default integration/gain shifts and plant coefficients
// - SAT_MAX/MIN  : 32-bit signed saturation limits (shared with controller)
// - sat64        : clamp a signed 64-bit value into 32 bits
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_B,
    MUL_C,
    ACC,
    INTEG,
    OUT
  } state_t;

  localparam int unsigned DEF_DT_SHIFT   = 3;
  localparam int unsigned DEF_GAIN_SHIFT = 2;
  localparam int          DEF_B_COEF     = 6;
  localparam int          DEF_C_COEF     = 10;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  // In range when the top 33 bits are all copies of the sign bit.
  function automatic logic [31:0] sat64(input logic [63:0] v);
    logic [31:0] r;
    if (v[63:31] == '0 || v[63:31] == '1) r = v[31:0];
    else if (v[63])                       r = SAT_MIN;
    else                                  r = SAT_MAX;
    return r;
  endfunction

endpackage

// File: rtl/sat_add32.sv
// Signed 32-bit saturating add/subtract.
// - a, b : signed operands
// - sub  : 1 = a - b, 0 = a + b
// - sum  : result clamped to SAT_MIN..SAT_MAX
module sat_add32
  import pid_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum
);

  logic [32:0] wide;

  always_comb begin
    wide = sub ? ({a[31], a} - {b[31], b}) : ({a[31], a} + {b[31], b});
    // Overflow when bit 32 and bit 31 of the 33-bit result disagree.
    if (wide[32] != wide[31]) sum = wide[32] ? SAT_MIN : SAT_MAX;
    else                      sum = wide[31:0];
  end

endmodule

// File: rtl/pid_plant_model.sv
// Second-order plant: ydd = (u - B*yd - C*y) >>> GAIN_SHIFT, forward Euler
// with step 2^-DT_SHIFT, one shared multiplier sequenced by a 6-state FSM.
// - clk, rst (sync, active-low), clear (sync state clear, below rst)
// - u_in/u_valid/u_ready : control-effort handshake (ready only in IDLE)
// - y_out/yd_out/y_valid : plant output and velocity, one-cycle valid pulse
// - step_cnt             : completed steps, wraps at 16 bits
module pid_plant_model
  import pid_pkg::*;
#(
  parameter int unsigned DT_SHIFT   = DEF_DT_SHIFT,
  parameter int unsigned GAIN_SHIFT = DEF_GAIN_SHIFT,
  parameter int          B_COEF     = DEF_B_COEF,
  parameter int          C_COEF     = DEF_C_COEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [31:0] u_in,
  input  logic        u_valid,
  output logic        u_ready,
  output logic [31:0] y_out,
  output logic [31:0] yd_out,
  output logic        y_valid,
  output logic [15:0] step_cnt
);

  localparam logic [31:0] B_W = 32'(B_COEF);
  localparam logic [31:0] C_W = 32'(C_COEF);

  state_t      state, state_next;
  logic [31:0] u_reg, prod, acc, ydd, y, yd;

  logic [31:0] mul_coef, mul_opnd;
  logic [63:0] mul_full;
  logic [31:0] acc_sum, ydd_sum, y_sum, yd_sum;
  logic [31:0] yd_step, ydd_step;
  logic        xfer;

  assign xfer = u_valid && u_ready;

  // Shared multiplier: B*yd in MUL_B, C*y otherwise (used in MUL_C).
  always_comb begin
    mul_coef = (state == MUL_B) ? B_W : C_W;
    mul_opnd = (state == MUL_B) ? yd  : y;
    mul_full = $signed({{32{mul_coef[31]}}, mul_coef}) *
               $signed({{32{mul_opnd[31]}}, mul_opnd});
  end

  assign yd_step  = 32'($signed(yd)  >>> DT_SHIFT);
  assign ydd_step = 32'($signed(ydd) >>> DT_SHIFT);

  sat_add32 u_acc (.a(u_reg), .b(prod),     .sub(1'b1), .sum(acc_sum));
  sat_add32 u_ydd (.a(acc),   .b(prod),     .sub(1'b1), .sum(ydd_sum));
  sat_add32 u_y   (.a(y),     .b(yd_step),  .sub(1'b0), .sum(y_sum));
  sat_add32 u_yd  (.a(yd),    .b(ydd_step), .sub(1'b0), .sum(yd_sum));

  // State register
  always_ff @(posedge clk) begin
    if (!rst)       state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (xfer) state_next = MUL_B;
      MUL_B:   state_next = MUL_C;
      MUL_C:   state_next = ACC;
      ACC:     state_next = INTEG;
      INTEG:   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    u_ready = (state == IDLE);
    y_valid = (state == OUT);
  end

  // Datapath. The visible outputs and step count are loaded on the edge into
  // OUT with the freshly integrated values, so they are already stable while
  // y_valid is high in OUT.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      u_reg    <= '0;
      prod     <= '0;
      acc      <= '0;
      ydd      <= '0;
      y        <= '0;
      yd       <= '0;
      y_out    <= '0;
      yd_out   <= '0;
      step_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (xfer) u_reg <= u_in;
        MUL_B: prod <= sat64(mul_full);
        MUL_C: begin
          acc  <= acc_sum;
          prod <= sat64(mul_full);
        end
        ACC: ydd <= 32'($signed(ydd_sum) >>> GAIN_SHIFT);
        INTEG: begin
          y        <= y_sum;
          yd       <= yd_sum;
          y_out    <= y_sum;
          yd_out   <= yd_sum;
          step_cnt <= step_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_plant_model.sv
module tb_pid_plant_model;

  localparam int unsigned DT = 3;
  localparam int unsigned GS = 2;
  localparam longint      BC = 6;
  localparam longint      CC = 10;
  localparam longint      LMAX = 64'sd2147483647;
  localparam longint      LMIN = -64'sd2147483648;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [31:0] u_in;
  logic        u_valid;
  logic        u_ready;
  logic [31:0] y_out;
  logic [31:0] yd_out;
  logic        y_valid;
  logic [15:0] step_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference plant state
  longint      m_y, m_yd;
  logic [15:0] m_cnt;

  pid_plant_model #(.DT_SHIFT(DT), .GAIN_SHIFT(GS), .B_COEF(6), .C_COEF(10)) dut (
    .clk(clk), .rst(rst), .clear(clear), .u_in(u_in), .u_valid(u_valid),
    .u_ready(u_ready), .y_out(y_out), .yd_out(yd_out), .y_valid(y_valid),
    .step_cnt(step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > LMAX) return LMAX;
    if (v < LMIN) return LMIN;
    return v;
  endfunction

  // One plant step straight from the difference equations.
  task automatic model_step(input logic [31:0] u);
    longint uu, ydd, ny, nyd;
    uu  = longint'($signed(u));
    ydd = sat(sat(uu - sat(BC * m_yd)) - sat(CC * m_y)) >>> GS;
    ny  = sat(m_y + (m_yd >>> DT));
    nyd = sat(m_yd + (ydd >>> DT));
    m_y   = ny;
    m_yd  = nyd;
    m_cnt = m_cnt + 16'd1;
  endtask

  task automatic model_reset();
    m_y = 0; m_yd = 0; m_cnt = '0;
  endtask

  // Called at a negedge. Applies one u, optionally pulses a stray u_valid
  // one cycle after the accept, and checks latency/outputs against the model.
  task automatic do_step(input logic [31:0] u, input bit bp);
    int unsigned k;
    k = 0;
    while (!u_ready && k < 20) begin @(negedge clk); k++; end
    check("ready_wait", longint'(u_ready), 1);
    u_in = u; u_valid = 1'b1;
    @(negedge clk);
    if (bp) begin
      check("bp_ready_low", longint'(u_ready), 0);
      u_in = 32'd500; u_valid = 1'b1;
    end else begin
      u_valid = 1'b0;
    end
    k = 0;
    while (!y_valid && k < 12) begin @(negedge clk); u_valid = 1'b0; k++; end
    check("latency", longint'(k), 4);
    model_step(u);
    check("y_out",    longint'($signed(y_out)),  m_y);
    check("yd_out",   longint'($signed(yd_out)), m_yd);
    check("step_cnt", longint'(step_cnt),        longint'(m_cnt));
    @(negedge clk);
    check("pulse_width", longint'(y_valid), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; u_valid = 1'b1; u_in = 32'd1234;
    repeat (2) @(negedge clk);
    rst = 1'b1; u_valid = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          rst_before;
    logic [31:0] u;
    int          exp_y;
    int          exp_yd;
  } vec_t;

  vec_t tbl[5];

  initial begin
    bit seen;
    logic [31:0] ru;

    tbl[0] = '{1'b1, 32'd1024, 0, 32};
    tbl[1] = '{1'b0, 32'd1024, 4, 58};
    tbl[2] = '{1'b0, 32'd1024, 11, 77};
    tbl[3] = '{1'b1, 32'hFFFF_FFFF, 0, -1};
    tbl[4] = '{1'b0, 32'd0, -1, -1};

    rst = 1'b0; clear = 1'b0; u_valid = 1'b0; u_in = '0;
    model_reset();

    // Reset values, with u_valid held high during reset
    do_reset();
    check("rst_y_out",    longint'($signed(y_out)),  0);
    check("rst_yd_out",   longint'($signed(yd_out)), 0);
    check("rst_step_cnt", longint'(step_cnt),        0);
    check("rst_y_valid",  longint'(y_valid),         0);
    check("rst_u_ready",  longint'(u_ready),         1);
    @(negedge clk);
    check("rst_no_xfer",  longint'(u_ready),         1);

    // Table: step response and negative floor
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].rst_before) do_reset();
      do_step(tbl[i].u, 1'b0);
      check("tbl_y",  longint'($signed(y_out)),  longint'(tbl[i].exp_y));
      check("tbl_yd", longint'($signed(yd_out)), longint'(tbl[i].exp_yd));
    end

    // Back-pressure: stray u_valid one cycle after accept is ignored
    do_step(32'd300, 1'b1);
    do_step(32'hFFFF_F000, 1'b1);

    // Clear in MUL_C aborts the step
    @(negedge clk);
    u_in = 32'd777; u_valid = 1'b1;
    @(negedge clk);
    u_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_u_ready",  longint'(u_ready),         1);
    check("clr_y_out",    longint'($signed(y_out)),  0);
    check("clr_yd_out",   longint'($signed(yd_out)), 0);
    check("clr_step_cnt", longint'(step_cnt),        0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (y_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("clr_no_pulse", longint'(seen), 0);
    model_reset();

    // u_valid together with clear is dropped
    clear = 1'b1; u_valid = 1'b1; u_in = 32'd4096;
    @(negedge clk);
    clear = 1'b0; u_valid = 1'b0;
    check("clr_drop_ready", longint'(u_ready), 1);
    repeat (6) @(negedge clk);
    check("clr_drop_cnt", longint'(step_cnt), 0);
    do_step(32'd1024, 1'b0);
    check("clr_restep_y",  longint'($signed(y_out)),  0);
    check("clr_restep_yd", longint'($signed(yd_out)), 32);

    // Reset mid-step (INTEG) aborts with state zeroed
    @(negedge clk);
    u_in = 32'd2048; u_valid = 1'b1;
    @(negedge clk);
    u_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mrst_y_valid", longint'(y_valid),  0);
    check("mrst_ready",   longint'(u_ready),  1);
    check("mrst_cnt",     longint'(step_cnt), 0);
    check("mrst_yd",      longint'($signed(yd_out)), 0);
    model_reset();

    // Saturation: drive maximum effort, then minimum
    for (int i = 0; i < 25; i++) do_step(32'h7FFF_FFFF, 1'b0);
    for (int i = 0; i < 25; i++) do_step(32'h8000_0000, 1'b0);

    // Randomized steps mixing small values and extremes
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       ru = 32'($signed($urandom_range(0, 8191)) - 4096);
        1:       ru = 32'h7FFF_FFFF;
        2:       ru = 32'h8000_0000;
        default: ru = $urandom;
      endcase
      do_step(ru, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
